// File: rtl/key_pkg.sv
// Shared types and width helpers for the multi-channel key conditioner.
// Cycle-count defaults target a 100 MHz clock.
package key_pkg;

   typedef enum logic [1:0] {
      IDLE,
      PRESSED,
      HELD
   } chan_st_e;

   localparam int unsigned DEF_N_KEYS   = 4;
   localparam int unsigned DEF_DEBOUNCE = 1000000;
   localparam int unsigned DEF_DELAY    = 50000000;
   localparam int unsigned DEF_RATE     = 10000000;

   function automatic int unsigned db_w(input int unsigned n);
      return $clog2(n + 1);
   endfunction

   function automatic int unsigned tc_w(input int unsigned n);
      return $clog2(n) + 1;
   endfunction

endpackage

// File: rtl/key_if.sv
// Key bundle between the board buttons and the conditioner.
// master drives raw keys and repeat enables; slave returns events.
interface key_if #(
   parameter int unsigned N_KEYS = 4
);

   logic [N_KEYS-1:0] key;
   logic [N_KEYS-1:0] repeat_en;
   logic [N_KEYS-1:0] key_level;
   logic [N_KEYS-1:0] key_press;
   logic [N_KEYS-1:0] key_release;
   logic [N_KEYS-1:0] key_hold;

   modport master (
      output key,
      output repeat_en,
      input  key_level,
      input  key_press,
      input  key_release,
      input  key_hold
   );

   modport slave (
      input  key,
      input  repeat_en,
      output key_level,
      output key_press,
      output key_release,
      output key_hold
   );

endinterface

// File: rtl/key_debounce_chan.sv
// One key channel: synchroniser, debounce counter, press/hold FSM
// with auto-repeat.
module key_debounce_chan
   import key_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES     = DEF_DEBOUNCE,
   parameter int unsigned REPEAT_DELAY_CYCLES = DEF_DELAY,
   parameter int unsigned REPEAT_RATE_CYCLES  = DEF_RATE,
   parameter bit          ACTIVE_HIGH         = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_i,
   input  logic repeat_en_i,
   output logic level_o,
   output logic press_o,
   output logic release_o,
   output logic hold_o
);

   localparam int unsigned DW = db_w(DEBOUNCE_CYCLES);
   localparam int unsigned HW = tc_w(REPEAT_DELAY_CYCLES);
   localparam int unsigned RW = tc_w(REPEAT_RATE_CYCLES);

   localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(REPEAT_DELAY_CYCLES - 1);
   localparam logic [RW-1:0] RATE_LAST = HW'(0) == '0 ?
                                         RW'(REPEAT_RATE_CYCLES - 1) :
                                         '0;

   logic          raw;
   logic          sync1_q;
   logic          sync2_q;
   logic          level_q;
   logic          level_d;
   logic [DW-1:0] db_q;
   logic [DW-1:0] db_d;
   logic          rise;
   logic          fall;

   chan_st_e      state_q;
   logic [HW-1:0] hold_cnt_q;
   logic [RW-1:0] rate_cnt_q;
   logic          press_q;
   logic          release_q;
   logic          hold_q;

   assign raw = ACTIVE_HIGH ? key_i : ~key_i;

   // A level change is accepted on the DEBOUNCE_CYCLES-th differing sample.
   always_comb begin
      level_d = level_q;
      db_d    = '0;
      rise    = 1'b0;
      fall    = 1'b0;
      if (sync2_q != level_q) begin
         if (db_q == DB_LAST) begin
            level_d = ~level_q;
            rise    = ~level_q;
            fall    = level_q;
         end else begin
            db_d = db_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         db_q    <= '0;
      end else begin
         sync1_q <= raw;
         sync2_q <= sync1_q;
         level_q <= level_d;
         db_q    <= db_d;
      end
   end

   // Release wins over a coinciding repeat so press/release never overlap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         hold_cnt_q <= '0;
         rate_cnt_q <= '0;
         press_q    <= 1'b0;
         release_q  <= 1'b0;
         hold_q     <= 1'b0;
      end else begin
         press_q   <= 1'b0;
         release_q <= 1'b0;
         if (fall) begin
            state_q    <= IDLE;
            release_q  <= 1'b1;
            hold_q     <= 1'b0;
            hold_cnt_q <= '0;
            rate_cnt_q <= '0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (rise) begin
                     state_q    <= PRESSED;
                     press_q    <= 1'b1;
                     hold_cnt_q <= '0;
                  end
               end
               PRESSED: begin
                  if (hold_cnt_q == HOLD_LAST) begin
                     state_q    <= HELD;
                     hold_q     <= 1'b1;
                     hold_cnt_q <= '0;
                     rate_cnt_q <= '0;
                     press_q    <= repeat_en_i;
                  end else begin
                     hold_cnt_q <= hold_cnt_q + 1'b1;
                  end
               end
               HELD: begin
                  if (!repeat_en_i) begin
                     rate_cnt_q <= '0;
                  end else if (rate_cnt_q == RATE_LAST) begin
                     press_q    <= 1'b1;
                     rate_cnt_q <= '0;
                  end else begin
                     rate_cnt_q <= rate_cnt_q + 1'b1;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign level_o   = level_q;
   assign press_o   = press_q;
   assign release_o = release_q;
   assign hold_o    = hold_q;

endmodule

// File: rtl/key_debounce_multi.sv
// N-channel push-button conditioner; fans the key bundle out to
// independent per-key channels.
module key_debounce_multi
   import key_pkg::*;
#(
   parameter int unsigned N_KEYS              = DEF_N_KEYS,
   parameter int unsigned DEBOUNCE_CYCLES     = DEF_DEBOUNCE,
   parameter int unsigned REPEAT_DELAY_CYCLES = DEF_DELAY,
   parameter int unsigned REPEAT_RATE_CYCLES  = DEF_RATE,
   parameter bit          ACTIVE_HIGH         = 1'b1
) (
   input logic clk,
   input logic rst_n,
   key_if.slave bus
);

   for (genvar g = 0; g < N_KEYS; g++) begin : g_chan
      key_debounce_chan #(
         .DEBOUNCE_CYCLES     (DEBOUNCE_CYCLES),
         .REPEAT_DELAY_CYCLES (REPEAT_DELAY_CYCLES),
         .REPEAT_RATE_CYCLES  (REPEAT_RATE_CYCLES),
         .ACTIVE_HIGH         (ACTIVE_HIGH)
      ) u_chan (
         .clk         (clk),
         .rst_n       (rst_n),
         .key_i       (bus.key[g]),
         .repeat_en_i (bus.repeat_en[g]),
         .level_o     (bus.key_level[g]),
         .press_o     (bus.key_press[g]),
         .release_o   (bus.key_release[g]),
         .hold_o      (bus.key_hold[g])
      );
   end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Directed bench for key_debounce_multi with short cycle parameters
// (debounce 4, repeat delay 20, repeat rate 8).
module tb_key_debounce_multi;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;

   key_if #(.N_KEYS(4)) bus ();

   key_debounce_multi #(
      .N_KEYS              (4),
      .DEBOUNCE_CYCLES     (4),
      .REPEAT_DELAY_CYCLES (20),
      .REPEAT_RATE_CYCLES  (8),
      .ACTIVE_HIGH         (1'b1)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [3:0] ep;
      n_cmp         = 0;
      n_err         = 0;
      rst_n         = 1'b0;
      bus.key       = '0;
      bus.repeat_en = '0;
      repeat (3) tick();
      chk("rst_level", 32'(bus.key_level), 0);
      chk("rst_press", 32'(bus.key_press), 0);
      chk("rst_release", 32'(bus.key_release), 0);
      chk("rst_hold", 32'(bus.key_hold), 0);
      rst_n = 1'b1;
      tick();

      // 1: clean press, 15 cycles, then release
      bus.key = 4'b0001;
      for (int c = 1; c <= 15; c++) begin
         tick();
         ep = (c == 6) ? 4'b0001 : 4'b0000;
         chk($sformatf("s1_press_c%0d", c), 32'(bus.key_press), 32'(ep));
         if (c == 5) chk("s1_level_c5", 32'(bus.key_level), 0);
         if (c == 6) chk("s1_level_c6", 32'(bus.key_level), 1);
      end
      bus.key = 4'b0000;
      for (int c = 1; c <= 7; c++) begin
         tick();
         ep = (c == 6) ? 4'b0001 : 4'b0000;
         chk($sformatf("s1_rel_c%0d", c), 32'(bus.key_release), 32'(ep));
      end
      chk("s1_level_end", 32'(bus.key_level), 0);
      repeat (3) tick();

      // 2: bounce on key[1], then a stable press
      for (int i = 0; i < 10; i++) begin
         bus.key[1] = (i % 2 == 0);
         repeat (2) begin
            tick();
            chk("s2_bounce_press", 32'(bus.key_press), 0);
            chk("s2_bounce_level", 32'(bus.key_level), 0);
         end
      end
      bus.key[1] = 1'b1;
      for (int c = 1; c <= 7; c++) begin
         tick();
         ep = (c == 6) ? 4'b0010 : 4'b0000;
         chk($sformatf("s2_press_c%0d", c), 32'(bus.key_press), 32'(ep));
      end
      bus.key = 4'b0000;
      repeat (12) tick();

      // 3: auto-repeat on key[2]; release lands on a repeat slot
      bus.repeat_en = 4'b0100;
      bus.key       = 4'b0100;
      for (int c = 1; c <= 52; c++) begin
         tick();
         ep = (c == 6 || c == 26 || c == 34 || c == 42 || c == 50) ?
              4'b0100 : 4'b0000;
         chk($sformatf("s3_press_c%0d", c), 32'(bus.key_press), 32'(ep));
         if (c == 25) chk("s3_hold_c25", 32'(bus.key_hold), 0);
         if (c == 26) chk("s3_hold_c26", 32'(bus.key_hold), 32'h4);
      end
      bus.key = 4'b0000;
      repeat (6) tick();
      chk("s3_rel", 32'(bus.key_release), 32'h4);
      chk("s3_rel_press", 32'(bus.key_press), 0);
      chk("s3_rel_hold", 32'(bus.key_hold), 0);
      repeat (5) tick();

      // 4: no repeat, then release
      bus.repeat_en = 4'b0000;
      bus.key       = 4'b0100;
      for (int c = 1; c <= 52; c++) begin
         tick();
         ep = (c == 6) ? 4'b0100 : 4'b0000;
         chk($sformatf("s4_press_c%0d", c), 32'(bus.key_press), 32'(ep));
         if (c == 25) chk("s4_hold_c25", 32'(bus.key_hold), 0);
         if (c == 26) chk("s4_hold_c26", 32'(bus.key_hold), 32'h4);
      end
      bus.key = 4'b0000;
      repeat (5) tick();
      chk("s4_r5_hold", 32'(bus.key_hold), 32'h4);
      chk("s4_r5_level", 32'(bus.key_level), 32'h4);
      chk("s4_r5_rel", 32'(bus.key_release), 0);
      tick();
      chk("s4_r6_rel", 32'(bus.key_release), 32'h4);
      chk("s4_r6_hold", 32'(bus.key_hold), 0);
      chk("s4_r6_level", 32'(bus.key_level), 0);
      chk("s4_r6_press", 32'(bus.key_press), 0);
      tick();
      chk("s4_r7_rel", 32'(bus.key_release), 0);
      repeat (3) tick();

      // 5: simultaneous press on key[0] and key[3]
      bus.key = 4'b1001;
      for (int c = 1; c <= 7; c++) begin
         tick();
         ep = (c == 6) ? 4'b1001 : 4'b0000;
         chk($sformatf("s5_press_c%0d", c), 32'(bus.key_press), 32'(ep));
      end
      chk("s5_level", 32'(bus.key_level), 32'h9);
      bus.key = 4'b0000;
      repeat (10) tick();
      chk("s5_level_end", 32'(bus.key_level), 0);

      // 6: asynchronous reset while HELD, key kept down
      bus.key = 4'b0001;
      repeat (30) tick();
      chk("s6_hold_pre", 32'(bus.key_hold), 1);
      chk("s6_level_pre", 32'(bus.key_level), 1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("s6_async_level", 32'(bus.key_level), 0);
      chk("s6_async_hold", 32'(bus.key_hold), 0);
      chk("s6_async_press", 32'(bus.key_press), 0);
      chk("s6_async_rel", 32'(bus.key_release), 0);
      repeat (2) tick();
      rst_n = 1'b1;
      for (int c = 1; c <= 26; c++) begin
         tick();
         ep = (c == 6) ? 4'b0001 : 4'b0000;
         chk($sformatf("s6_press_c%0d", c), 32'(bus.key_press), 32'(ep));
         if (c == 25) chk("s6_hold_c25", 32'(bus.key_hold), 0);
         if (c == 26) chk("s6_hold_c26", 32'(bus.key_hold), 1);
      end
      bus.key = 4'b0000;
      repeat (10) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
